// File: rtl/gpio_poller.sv
// gpio_poller: bus initiator for the GPIO register block.
// After reset it programs both direction registers. It then polls input
// ports A and B every PERIOD cycles and reports pin changes through a
// valid/ready event channel. It also forwards local single-byte writes to
// the output registers.
module gpio_poller #(
    parameter int unsigned PERIOD     = 1000,
    parameter logic [7:0]  DIR_A_INIT = 8'h00,
    parameter logic [7:0]  DIR_B_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr_req,
    input  logic        wr_port,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [2:0]  gpio_sel,
    output logic        gpio_we,
    output logic [31:0] gpio_di,
    input  logic [31:0] gpio_do,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_data,
    output logic [15:0] evt_changed
);

    // GPIO block register map
    localparam logic [2:0] SEL_OUT_A = 3'b000;
    localparam logic [2:0] SEL_DIR_A = 3'b001;
    localparam logic [2:0] SEL_IN_A  = 3'b010;
    localparam logic [2:0] SEL_OUT_B = 3'b011;
    localparam logic [2:0] SEL_DIR_B = 3'b100;
    localparam logic [2:0] SEL_IN_B  = 3'b101;

    localparam logic [15:0] TICK_RELOAD = 16'(PERIOD - 32'd1);

    typedef enum logic [2:0] {
        INIT_A = 3'd0,
        INIT_B = 3'd1,
        IDLE   = 3'd2,
        WRITE  = 3'd3,
        RD_A   = 3'd4,
        RD_B   = 3'd5,
        CMP    = 3'd6,
        EVT    = 3'd7
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] tick_cnt_r;
    logic        tick_pending_r;
    logic [15:0] cur_r;
    logic [15:0] prev_r;
    logic        first_flag_r;
    logic        en_d_r;
    logic [15:0] evt_data_r;
    logic [15:0] evt_changed_r;
    logic        wr_port_r;
    logic [7:0]  wr_byte_r;
    logic        report_s;
    logic        rd_a_entry_s;
    logic        unused_gpio_do_s;

    // The GPIO data bus is 32 bits wide, but a register holds only one byte.
    function automatic logic [31:0] byte_word(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

    // An event is produced for the first sample after (re)enable or on any pin change.
    assign report_s     = first_flag_r || (cur_r != prev_r);
    assign rd_a_entry_s = (state_r == IDLE) && (state_next_s == RD_A);
    assign evt_data     = evt_data_r;
    assign evt_changed  = evt_changed_r;

    // Only the pin bytes of each input register are used.
    assign unused_gpio_do_s = ^{gpio_do[31:24], gpio_do[7:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and bus/handshake outputs, decoded from the state register
    always_comb begin
        state_next_s = state_r;
        gpio_sel     = SEL_OUT_A;
        gpio_we      = 1'b0;
        gpio_di      = 32'h0000_0000;
        wr_ack       = 1'b0;
        evt_valid    = 1'b0;
        if (reset) begin
            state_next_s = INIT_A;
        end else begin
            case (state_r)
                INIT_A: begin
                    gpio_sel     = SEL_DIR_A;
                    gpio_we      = 1'b1;
                    gpio_di      = byte_word(DIR_A_INIT);
                    state_next_s = INIT_B;
                end
                INIT_B: begin
                    gpio_sel     = SEL_DIR_B;
                    gpio_we      = 1'b1;
                    gpio_di      = byte_word(DIR_B_INIT);
                    state_next_s = IDLE;
                end
                IDLE: begin
                    // A local write takes priority; a pending sample waits one cycle.
                    if (wr_req) begin
                        state_next_s = WRITE;
                    end else if (tick_pending_r && en) begin
                        state_next_s = RD_A;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                WRITE: begin
                    gpio_sel     = wr_port_r ? SEL_OUT_B : SEL_OUT_A;
                    gpio_we      = 1'b1;
                    gpio_di      = byte_word(wr_byte_r);
                    wr_ack       = 1'b1;
                    state_next_s = IDLE;
                end
                RD_A: begin
                    gpio_sel     = SEL_IN_A;
                    state_next_s = RD_B;
                end
                RD_B: begin
                    gpio_sel     = SEL_IN_B;
                    state_next_s = CMP;
                end
                CMP: begin
                    if (report_s) begin
                        state_next_s = EVT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                EVT: begin
                    evt_valid = 1'b1;
                    if (evt_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = EVT;
                    end
                end
                default: begin
                    state_next_s = INIT_A;
                end
            endcase
        end
    end

    // Poll timer: ticks that occur while the poller is busy collapse into one sticky request.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r     <= TICK_RELOAD;
            tick_pending_r <= 1'b0;
        end else if (!en) begin
            tick_cnt_r     <= TICK_RELOAD;
            tick_pending_r <= 1'b0;
        end else if (tick_cnt_r == 16'd0) begin
            tick_cnt_r     <= TICK_RELOAD;
            tick_pending_r <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r - 16'd1;
            if (rd_a_entry_s) begin
                tick_pending_r <= 1'b0;
            end
        end
    end

    // Sample capture, change detection, event holding and write staging
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_r         <= 16'h0000;
            prev_r        <= 16'h0000;
            first_flag_r  <= 1'b1;
            en_d_r        <= 1'b0;
            evt_data_r    <= 16'h0000;
            evt_changed_r <= 16'h0000;
            wr_port_r     <= 1'b0;
            wr_byte_r     <= 8'h00;
        end else begin
            en_d_r <= en;
            // wr_req is held until it is acknowledged, so capturing in IDLE gives a stable write.
            if ((state_r == IDLE) && wr_req) begin
                wr_port_r <= wr_port;
                wr_byte_r <= wr_data;
            end
            if (state_r == RD_A) begin
                cur_r[7:0] <= gpio_do[23:16];
            end
            if (state_r == RD_B) begin
                cur_r[15:8] <= gpio_do[15:8];
            end
            if (state_r == CMP) begin
                prev_r <= cur_r;
                if (report_s) begin
                    evt_data_r    <= cur_r;
                    evt_changed_r <= first_flag_r ? 16'hFFFF : (cur_r ^ prev_r);
                end
            end
            // Disabling the poller makes the next sample report every pin again.
            if (en_d_r && !en) begin
                first_flag_r <= 1'b1;
            end else if (state_r == CMP) begin
                first_flag_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_poller.sv
// tb_gpio_poller: directed stimulus with a queue-based scoreboard for
// gpio_poller. A behavioural GPIO read mux provides the pins. A monitor
// fork checks bus writes and accepted events against the expected queues.
module tb_gpio_poller;

    localparam int unsigned PERIOD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr_req;
    logic        wr_port;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [2:0]  gpio_sel;
    logic        gpio_we;
    logic [31:0] gpio_di;
    logic [31:0] gpio_do;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_data;
    logic [15:0] evt_changed;
    logic [7:0]  pin_a;
    logic [7:0]  pin_b;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // expected bus writes {wr_ack, sel, di} and accepted events {data, changed}
    logic [35:0] bus_q[$];
    logic [31:0] evt_q[$];

    gpio_poller #(
        .PERIOD    (PERIOD),
        .DIR_A_INIT(8'hF0),
        .DIR_B_INIT(8'h0F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_req     (wr_req),
        .wr_port    (wr_port),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .gpio_sel   (gpio_sel),
        .gpio_we    (gpio_we),
        .gpio_di    (gpio_di),
        .gpio_do    (gpio_do),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_changed(evt_changed)
    );

    always #5 clk = ~clk;

    // GPIO read mux; filler bytes around the pins catch wrong byte lanes.
    always_comb begin
        case (gpio_sel)
            3'b010:  gpio_do = {8'hAA, pin_a, 16'h5555};
            3'b101:  gpio_do = {16'h6666, pin_b, 8'h77};
            default: gpio_do = 32'h1234_5678;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = max_cyc + 1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); #1;
            if (evt_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int max_cyc, output int n);
        n = max_cyc + 1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); #1;
            if (wr_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic monitor_loop();
        logic        last_valid = 1'b0;
        logic        last_ready = 1'b0;
        logic [31:0] last_word  = 32'h0;
        logic [35:0] exp_b;
        logic [31:0] exp_e;
        forever begin
            @(negedge clk);
            chk("wr_ack_decode", 64'(wr_ack),
                64'(gpio_we && ((gpio_sel == 3'b000) || (gpio_sel == 3'b011))));
            if (gpio_we) begin
                chk("bus_write_expected", 64'(bus_q.size() > 0), 64'd1);
                if (bus_q.size() > 0) begin
                    exp_b = bus_q.pop_front();
                    chk("bus_write", 64'({wr_ack, gpio_sel, gpio_di}), 64'(exp_b));
                end
            end
            if (evt_valid && evt_ready) begin
                chk("evt_expected", 64'(evt_q.size() > 0), 64'd1);
                if (evt_q.size() > 0) begin
                    exp_e = evt_q.pop_front();
                    chk("evt_payload", 64'({evt_data, evt_changed}), 64'(exp_e));
                end
            end
            if (evt_valid && last_valid && !last_ready) begin
                chk("evt_stable", 64'({evt_data, evt_changed}), 64'(last_word));
            end
            last_valid = evt_valid;
            last_ready = evt_ready;
            last_word  = {evt_data, evt_changed};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        fork
            monitor_loop();
        join_none

        reset = 1'b1; en = 1'b0; wr_req = 1'b0; wr_port = 1'b0; wr_data = 8'h00;
        evt_ready = 1'b1; pin_a = 8'h5A; pin_b = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio_sel",    64'(gpio_sel),    64'(3'b000));
        chk("rst_gpio_we",     64'(gpio_we),     64'd0);
        chk("rst_gpio_di",     64'(gpio_di),     64'd0);
        chk("rst_wr_ack",      64'(wr_ack),      64'd0);
        chk("rst_evt_valid",   64'(evt_valid),   64'd0);
        chk("rst_evt_data",    64'(evt_data),    64'd0);
        chk("rst_evt_changed", 64'(evt_changed), 64'd0);

        // init writes, then the first sample after enable reports all pins
        bus_q.push_back({1'b0, 3'b001, 32'h0000_00F0});
        bus_q.push_back({1'b0, 3'b100, 32'h0000_000F});
        evt_q.push_back({16'h3C5A, 16'hFFFF});
        reset = 1'b0; en = 1'b1;
        #1;
        chk("init_cycle1_sel", 64'(gpio_sel), 64'(3'b001));
        @(posedge clk); #1;
        chk("init_cycle2_sel", 64'(gpio_sel), 64'(3'b100));
        @(posedge clk); #1;
        chk("idle_cycle3_we", 64'(gpio_we), 64'd0);
        wait_valid(20, n);
        chk("first_evt_latency", 64'(n), 64'd10);

        // unchanged sample produces nothing; then pin A bit 0 toggles
        repeat (10) @(posedge clk);
        #1;
        pin_a = 8'h5B;
        evt_q.push_back({16'h3C5B, 16'h0001});
        wait_valid(20, n);
        chk("change_evt_latency", 64'(n), 64'd6);

        // local write to port B output register
        @(posedge clk); #1;
        wr_req = 1'b1; wr_port = 1'b1; wr_data = 8'hA5;
        bus_q.push_back({1'b1, 3'b011, 32'h0000_00A5});
        wait_ack(5, n);
        chk("wr_ack_latency", 64'(n), 64'd1);
        wr_req = 1'b0;
        @(posedge clk); #1;
        chk("wr_ack_one_cycle", 64'(wr_ack), 64'd0);

        // write request lands in the same IDLE cycle as a pending tick
        @(posedge clk); #1;
        wr_req = 1'b1; wr_port = 1'b0; wr_data = 8'hC3;
        bus_q.push_back({1'b1, 3'b000, 32'h0000_00C3});
        wait_ack(5, n);
        chk("wr_tick_ack_latency", 64'(n), 64'd1);
        wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rd_a_after_write", 64'(gpio_sel), 64'(3'b010));

        // backpressure: event held for 3 periods while pins keep changing
        repeat (4) @(posedge clk);
        #1;
        evt_ready = 1'b0; pin_b = 8'h81;
        evt_q.push_back({16'h815B, 16'hBD00});
        wait_valid(20, n);
        chk("bp_evt_latency", 64'(n), 64'd5);
        for (int i = 1; i <= 3 * int'(PERIOD); i++) begin
            @(posedge clk); #1;
            if (i == 5) pin_a = 8'h00;
            if (i == 12) pin_b = 8'hFF;
        end
        chk("bp_valid_held", 64'(evt_valid), 64'd1);
        chk("bp_data_held",  64'(evt_data),  64'(16'h815B));
        evt_q.push_back({16'hFF00, 16'h7E5B});
        evt_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop_after_accept", 64'(evt_valid), 64'd0);
        wait_valid(20, n);
        chk("collapsed_tick_latency", 64'(n), 64'd4);

        // reset while an event is waiting: event dropped, init repeats
        @(posedge clk); #1;
        evt_ready = 1'b0; pin_a = 8'h11;
        wait_valid(20, n);
        chk("pre_reset_evt_valid",   64'(evt_valid),   64'd1);
        chk("pre_reset_evt_changed", 64'(evt_changed), 64'(16'h0011));
        bus_q.push_back({1'b0, 3'b001, 32'h0000_00F0});
        bus_q.push_back({1'b0, 3'b100, 32'h0000_000F});
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_drops_valid", 64'(evt_valid), 64'd0);
        chk("reset_clears_data", 64'(evt_data),  64'd0);
        @(posedge clk); #1;
        evt_q.push_back({16'hFF11, 16'hFFFF});
        evt_ready = 1'b1; reset = 1'b0;
        wait_valid(20, n);
        chk("reinit_evt_latency", 64'(n), 64'd12);

        // disable/re-enable forces a full report of unchanged pins
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        evt_q.push_back({16'hFF11, 16'hFFFF});
        wait_valid(20, n);
        chk("reenable_evt_latency", 64'(n), 64'd12);

        repeat (20) @(posedge clk);
        #1;
        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("evt_q_drained", 64'(evt_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
